ether_packet_gen: RTL and testbench
===================================

Name: ether_packet_gen

Overview:
- Parametrised GMII frame generator; next generation of the fixed sample-packet transmitter.
- Runs in the 125 MHz TX domain, drives PHY TX pins directly and sequences the PHY reset.
- Builds complete Ethernet II frames: preamble, SFD, configurable header, patterned payload, computed FCS, enforced inter-frame gap, configurable frame count.

Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC; sent MSB byte first.
- SRC_MAC, 48'h000A35000001, source MAC; sent MSB byte first.
- ETHERTYPE, 16'h88B5, EtherType; sent MSB byte first.
- PAYLOAD_LEN, 46, payload bytes; values below 46 are zero-padded to 46.
- PAYLOAD_MODE, 0, 0 = incrementing pattern, 1 = constant PAYLOAD_BYTE.
- PAYLOAD_BYTE, 8'hA5, constant used when PAYLOAD_MODE = 1.
- IFG_CYCLES, 12, idle cycles between frames; values below 12 are treated as 12.
- FRAME_COUNT, 0, frames per enable session; 0 means continuous.
- PHY_RST_CYCLES, 1250, cycles that phy_rst_n is held low after reset.

Ports:
- clk_125  in  1  TX clock, 125 MHz.
- rst_n  in  1  asynchronous reset, active-low.
- enable  in  1  level; high requests frame generation.
- err_inject  in  1  when high during the PAYLOAD state, asserts phy_er that cycle.
- phy_rst  out  1  PHY reset, active-low.
- phy_en  out  1  GMII TX_EN.
- phy_er  out  1  GMII TX_ER.
- phy_data  out  8  GMII TXD.
- busy  out  1  high from the first preamble byte until the last IFG cycle.
- frame_done  out  1  one-cycle pulse on the last FCS byte.
- frame_seq  out  16  count of completed frames; wraps at 2^16.

Behaviour:
- Reset (rst_n low, asynchronous): phy_rst=0, phy_en=0, phy_er=0, phy_data=0, busy=0, frame_done=0, frame_seq=0, state=PHYRST, session count=0.
- All outputs are registered.
- PHYRST state:
  - phy_rst stays 0 for exactly PHY_RST_CYCLES clocks after rst_n deasserts, then goes 1.
  - Enable is ignored during PHYRST.
  - Then move to IDLE.
- IDLE:
  - If enable=1 at edge N and the session limit is not reached, phy_en=1 from edge N+1 with the first preamble byte.
  - Session count clears whenever enable=0 in IDLE.
- PREAMBLE: 7 cycles of 0x55.
- SFD: 1 cycle of 0xD5.
- HEADER: 14 cycles carrying DST_MAC, then SRC_MAC, then ETHERTYPE.
- PAYLOAD: L = max(PAYLOAD_LEN, 46) cycles; byte index i = 0..L-1.
  - Mode 0: byte = (frame_seq[7:0] + i) mod 256, for i < PAYLOAD_LEN; padding bytes are 0x00.
  - Mode 1: byte = PAYLOAD_BYTE for i < PAYLOAD_LEN; padding bytes are 0x00.
- FCS: 4 cycles.
  - CRC-32 (IEEE 802.3, reflected, poly 0x04C11DB7, init 0xFFFFFFFF, final complement) computed over header and payload, padding included.
  - Sent crc[7:0] first.
  - frame_done pulses on the 4th FCS cycle; frame_seq and session count increment on that same edge.
- IFG:
  - phy_en=0 and phy_data=0 for max(IFG_CYCLES, 12) cycles.
  - Then return to IDLE; a back-to-back frame may start on the following edge.
- phy_en length per frame is exactly 8 + 14 + L + 4 cycles, with no gaps.
- phy_er = err_inject only in PAYLOAD; 0 in all other states.
- enable falling mid-frame: the current frame and its IFG complete normally, and no new frame starts.
- FRAME_COUNT = N > 0: after N frames the block stays in IDLE until enable drops and rises again.
- rst_n asserted mid-frame: outputs return to reset values immediately (truncated frame) and the PHYRST sequence re-runs.
- frame_seq wraps 0xFFFF to 0x0000 without disturbing the frame.

Test Plan:
- Reset release with PHY_RST_CYCLES=4 and enable held 1 -> phy_rst low exactly 4 cycles after rst_n rises; first phy_en on the cycle after IDLE is entered; busy rises with phy_en.
- Defaults, one frame -> 72 phy_en cycles: 7x0x55, 0xD5, FF x6, 00 0A 35 00 00 01, 88 B5, payload 00..2D, then FCS; receiver CRC over bytes 9..72 leaves residue 0xC704DD7B.
- PAYLOAD_LEN=10, PAYLOAD_MODE=1 -> 10 bytes of 0xA5, then 36 bytes of 0x00; total phy_en 72 cycles; CRC residue check passes.
- FRAME_COUNT=3, enable held 1 -> exactly 3 frames separated by exactly 12 idle cycles; frame_seq ends at 3; a 2nd enable pulse yields 3 more frames.
- enable dropped in HEADER of frame 2 -> frame 2 completes intact; no frame 3; err_inject high for 2 payload cycles -> phy_er high on exactly those 2 cycles.
- rst_n pulsed low during PAYLOAD -> phy_en=0 within the same cycle (asynchronous); phy_rst=0; frame_seq=0; PHYRST sequence repeats.

Source files
------------

// File: rtl/ether_packet_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ether_packet_gen_if : control inputs, status and GMII TX pin bundle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ether_packet_gen_if;
   logic        enable;
   logic        err_inject;
   logic        phy_rst;
   logic        phy_en;
   logic        phy_er;
   logic [7:0]  phy_data;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_seq;

   modport master (
      input  enable,
      input  err_inject,
      output phy_rst,
      output phy_en,
      output phy_er,
      output phy_data,
      output busy,
      output frame_done,
      output frame_seq
   );

   modport slave (
      output enable,
      output err_inject,
      input  phy_rst,
      input  phy_en,
      input  phy_er,
      input  phy_data,
      input  busy,
      input  frame_done,
      input  frame_seq
   );
endinterface
`default_nettype wire

// File: rtl/ether_packet_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ether_packet_gen : GMII Ethernet II frame generator with PHY reset  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ether_packet_gen #(
   parameter logic [47:0] DST_MAC        = 48'hFFFFFFFFFFFF,
   parameter logic [47:0] SRC_MAC        = 48'h000A35000001,
   parameter logic [15:0] ETHERTYPE      = 16'h88B5,
   parameter int          PAYLOAD_LEN    = 46,
   parameter int          PAYLOAD_MODE   = 0,
   parameter logic [7:0]  PAYLOAD_BYTE   = 8'hA5,
   parameter int          IFG_CYCLES     = 12,
   parameter int          FRAME_COUNT    = 0,
   parameter int          PHY_RST_CYCLES = 1250
) (
   input wire logic           clk_125,
   input wire logic           rst_n,
   ether_packet_gen_if.master bus
);

   localparam int PAY_TOTAL = (PAYLOAD_LEN < 46) ? 46 : PAYLOAD_LEN;
   localparam int IFG_TOTAL = (IFG_CYCLES < 12) ? 12 : IFG_CYCLES;
   localparam int RST_WAIT  = (PHY_RST_CYCLES < 2) ? 0 : PHY_RST_CYCLES - 2;

   localparam logic [15:0]  PAY_LAST    = 16'(PAY_TOTAL - 1);
   localparam logic [15:0]  PAY_USED    = 16'(PAYLOAD_LEN);
   localparam logic [15:0]  IFG_LAST    = 16'(IFG_TOTAL - 1);
   localparam logic [15:0]  RST_LAST    = 16'(RST_WAIT);
   localparam logic [31:0]  SESSION_MAX = 32'(FRAME_COUNT);
   localparam logic [111:0] HDR         = {DST_MAC, SRC_MAC, ETHERTYPE};

   typedef enum logic [2:0] {
      S_PHYRST = 3'd0,
      S_IDLE   = 3'd1,
      S_PRE    = 3'd2,
      S_SFD    = 3'd3,
      S_HDR    = 3'd4,
      S_PAY    = 3'd5,
      S_FCS    = 3'd6,
      S_IFG    = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] sess_q, sess_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] frame_seq_q, frame_seq_d;
   logic        phy_rst_q, phy_rst_d;
   logic        phy_en_q, phy_en_d;
   logic        phy_er_q, phy_er_d;
   logic [7:0]  phy_data_q, phy_data_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;

   logic        session_full;
   logic [6:0]  hdr_lsb;
   logic [7:0]  hdr_byte;
   logic [7:0]  pay_byte;
   logic [7:0]  fcs_byte;
   logic [31:0] fcs;

   // Reflected CRC-32 (poly 0xEDB88320), one byte per call, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   always_comb begin
      session_full = (FRAME_COUNT != 0) && (sess_q >= SESSION_MAX);
      hdr_lsb      = 7'd104 - {cnt_q[3:0], 3'b000};
      hdr_byte     = HDR[hdr_lsb +: 8];
      if (cnt_q >= PAY_USED) begin
         pay_byte = 8'h00;
      end else if (PAYLOAD_MODE != 0) begin
         pay_byte = PAYLOAD_BYTE;
      end else begin
         pay_byte = frame_seq_q[7:0] + cnt_q[7:0];
      end
      fcs = ~crc_q;
      case (cnt_q[1:0])
         2'd0:    fcs_byte = fcs[7:0];
         2'd1:    fcs_byte = fcs[15:8];
         2'd2:    fcs_byte = fcs[23:16];
         default: fcs_byte = fcs[31:24];
      endcase
   end

   // Outputs are decoded from the current state and registered, so the pins
   // trail the state register by one clock.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sess_d       = sess_q;
      crc_d        = crc_q;
      frame_seq_d  = frame_seq_q;
      phy_rst_d    = 1'b1;
      phy_en_d     = 1'b0;
      phy_er_d     = 1'b0;
      phy_data_d   = 8'h00;
      busy_d       = 1'b0;
      frame_done_d = 1'b0;

      case (state_q)
         S_PHYRST: begin
            phy_rst_d = 1'b0;
            cnt_d     = cnt_q + 16'd1;
            if (cnt_q >= RST_LAST) begin
               state_d = S_IDLE;
               cnt_d   = 16'd0;
            end
         end
         S_IDLE: begin
            if (!bus.enable) begin
               sess_d = 32'd0;
            end else if (!session_full) begin
               state_d = S_PRE;
               cnt_d   = 16'd0;
            end
         end
         S_PRE: begin
            phy_en_d   = 1'b1;
            busy_d     = 1'b1;
            phy_data_d = 8'h55;
            crc_d      = 32'hFFFFFFFF;
            cnt_d      = cnt_q + 16'd1;
            if (cnt_q == 16'd6) begin
               state_d = S_SFD;
               cnt_d   = 16'd0;
            end
         end
         S_SFD: begin
            phy_en_d   = 1'b1;
            busy_d     = 1'b1;
            phy_data_d = 8'hD5;
            state_d    = S_HDR;
            cnt_d      = 16'd0;
         end
         S_HDR: begin
            phy_en_d   = 1'b1;
            busy_d     = 1'b1;
            phy_data_d = hdr_byte;
            crc_d      = crc32_byte(crc_q, hdr_byte);
            cnt_d      = cnt_q + 16'd1;
            if (cnt_q == 16'd13) begin
               state_d = S_PAY;
               cnt_d   = 16'd0;
            end
         end
         S_PAY: begin
            phy_en_d   = 1'b1;
            busy_d     = 1'b1;
            phy_er_d   = bus.err_inject;
            phy_data_d = pay_byte;
            crc_d      = crc32_byte(crc_q, pay_byte);
            cnt_d      = cnt_q + 16'd1;
            if (cnt_q == PAY_LAST) begin
               state_d = S_FCS;
               cnt_d   = 16'd0;
            end
         end
         S_FCS: begin
            phy_en_d   = 1'b1;
            busy_d     = 1'b1;
            phy_data_d = fcs_byte;
            cnt_d      = cnt_q + 16'd1;
            if (cnt_q == 16'd3) begin
               frame_done_d = 1'b1;
               frame_seq_d  = frame_seq_q + 16'd1;
               sess_d       = sess_q + 32'd1;
               state_d      = S_IFG;
               cnt_d        = 16'd0;
            end
         end
         S_IFG: begin
            busy_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
            // The IDLE decision is folded into the last gap cycle so that
            // back-to-back frames see exactly IFG_TOTAL idle clocks.
            if (cnt_q == IFG_LAST) begin
               cnt_d   = 16'd0;
               state_d = (bus.enable && !session_full) ? S_PRE : S_IDLE;
            end
         end
         default: begin
            state_d = S_PHYRST;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk_125 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_PHYRST;
         cnt_q        <= 16'd0;
         sess_q       <= 32'd0;
         crc_q        <= 32'hFFFFFFFF;
         frame_seq_q  <= 16'd0;
         phy_rst_q    <= 1'b0;
         phy_en_q     <= 1'b0;
         phy_er_q     <= 1'b0;
         phy_data_q   <= 8'h00;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sess_q       <= sess_d;
         crc_q        <= crc_d;
         frame_seq_q  <= frame_seq_d;
         phy_rst_q    <= phy_rst_d;
         phy_en_q     <= phy_en_d;
         phy_er_q     <= phy_er_d;
         phy_data_q   <= phy_data_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.phy_rst    = phy_rst_q;
   assign bus.phy_en     = phy_en_q;
   assign bus.phy_er     = phy_er_q;
   assign bus.phy_data   = phy_data_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_seq  = frame_seq_q;

endmodule
`default_nettype wire

// File: tb/tb_ether_packet_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ether_packet_gen : self-checking bench for ether_packet_gen      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ether_packet_gen;

   typedef struct {
      int         pos;
      logic [7:0] data;
   } hdr_vec_t;

   typedef struct {
      int          pay_len;
      int          pay_tot;
      logic        mode;
      logic [15:0] seq;
      int          er_lo;
      int          er_hi;
      int          gap;
   } exp_t;

   logic clk_125 = 1'b0;
   logic rst_n_a = 1'b1;
   logic rst_n_b = 1'b1;
   always #4 clk_125 = ~clk_125;

   ether_packet_gen_if ifa ();
   ether_packet_gen_if ifb ();

   ether_packet_gen #(
      .PHY_RST_CYCLES(4)
   ) u_a (
      .clk_125(clk_125),
      .rst_n  (rst_n_a),
      .bus    (ifa)
   );

   ether_packet_gen #(
      .PAYLOAD_LEN   (10),
      .PAYLOAD_MODE  (1),
      .FRAME_COUNT   (3),
      .PHY_RST_CYCLES(4)
   ) u_b (
      .clk_125(clk_125),
      .rst_n  (rst_n_b),
      .bus    (ifb)
   );

   int errors = 0;
   int checks = 0;

   hdr_vec_t    hdr_tab [22];
   exp_t        exp_a [$];
   exp_t        exp_b [$];

   logic [7:0]  fb [2][256];
   logic        fe [2][256];
   int          flen [2];
   int          gap [2];
   int          first_gap [2];
   int          done_pos [2];
   logic [15:0] done_seq [2];
   int          starts [2];
   bit          discard [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic frame_end(input int d);
      exp_t        e;
      int          len;
      int          nbad;
      logic [31:0] crc;
      logic [7:0]  b;
      logic [7:0]  want;
      logic        fbit;
      logic        er_want;
      logic [15:0] seq_next;
      len = flen[d];
      if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
         check($sformatf("dut%0d_unexpected_frame_len", d), len, 0);
         return;
      end
      if (d == 0) e = exp_a.pop_front();
      else        e = exp_b.pop_front();

      check($sformatf("dut%0d_seq%0d_frame_len", d, e.seq), len, 26 + e.pay_tot);
      for (int i = 0; i < 22; i++) begin
         check($sformatf("dut%0d_seq%0d_hdr[%0d]", d, e.seq, hdr_tab[i].pos),
               fb[d][hdr_tab[i].pos], hdr_tab[i].data);
      end

      nbad = 0;
      for (int i = 0; i < e.pay_tot && 22 + i < 256; i++) begin
         if (i >= e.pay_len) want = 8'h00;
         else if (e.mode)    want = 8'hA5;
         else                want = e.seq[7:0] + 8'(i);
         if (fb[d][22 + i] !== want) nbad++;
      end
      check($sformatf("dut%0d_seq%0d_payload_bad_bytes", d, e.seq), nbad, 0);

      // Receiver-side CRC in transmission bit order over header..FCS.
      crc = 32'hFFFFFFFF;
      for (int i = 8; i < len && i < 256; i++) begin
         b = fb[d][i];
         for (int k = 0; k < 8; k++) begin
            fbit = crc[31] ^ b[k];
            crc  = {crc[30:0], 1'b0} ^ (fbit ? 32'h04C11DB7 : 32'h0);
         end
      end
      check($sformatf("dut%0d_seq%0d_crc_residue", d, e.seq), crc, 32'hC704DD7B);

      nbad = 0;
      for (int i = 0; i < len && i < 256; i++) begin
         er_want = (e.er_lo >= 0) && (i >= 22 + e.er_lo) && (i <= 22 + e.er_hi);
         if (fe[d][i] !== er_want) nbad++;
      end
      check($sformatf("dut%0d_seq%0d_phy_er_bad_cycles", d, e.seq), nbad, 0);

      seq_next = e.seq + 16'd1;
      check($sformatf("dut%0d_seq%0d_done_pos", d, e.seq), done_pos[d], len);
      check($sformatf("dut%0d_seq%0d_seq_at_done", d, e.seq), done_seq[d], seq_next);
      if (e.gap > 0) begin
         check($sformatf("dut%0d_seq%0d_ifg", d, e.seq), first_gap[d], e.gap);
      end
   endtask

   task automatic mon(input int d, input logic en, input logic er, input logic [7:0] data,
                      input logic done, input logic [15:0] seq);
      if (en === 1'b1) begin
         if (flen[d] == 0) begin
            first_gap[d] = gap[d];
            starts[d]++;
            done_pos[d] = -1;
         end
         if (flen[d] < 256) begin
            fb[d][flen[d]] = data;
            fe[d][flen[d]] = er;
         end
         flen[d]++;
         if (done === 1'b1) begin
            done_pos[d] = flen[d];
            done_seq[d] = seq;
         end
      end else begin
         if (flen[d] != 0) begin
            if (discard[d]) discard[d] = 1'b0;
            else            frame_end(d);
            flen[d] = 0;
            gap[d]  = 0;
         end
         gap[d]++;
         if (er === 1'b1) check($sformatf("dut%0d_phy_er_idle", d), er, 1'b0);
      end
   endtask

   always @(negedge clk_125) begin
      mon(0, ifa.phy_en, ifa.phy_er, ifa.phy_data, ifa.frame_done, ifa.frame_seq);
      mon(1, ifb.phy_en, ifb.phy_er, ifb.phy_data, ifb.frame_done, ifb.frame_seq);
   end

   task automatic wait_starts(input int d, input int n, input int budget);
      int k;
      k = 0;
      while (starts[d] < n && k < budget) begin
         @(negedge clk_125);
         #1;
         k++;
      end
      if (starts[d] < n) check($sformatf("dut%0d_timeout_frame_starts", d), starts[d], n);
   endtask

   task automatic negs(input int n);
      repeat (n) begin
         @(negedge clk_125);
         #1;
      end
   endtask

   initial begin : main
      logic [175:0] hdr_ref;
      hdr_ref = {56'h55555555555555, 8'hD5, 48'hFFFFFFFFFFFF, 48'h000A35000001, 16'h88B5};
      for (int i = 0; i < 22; i++) begin
         hdr_tab[i].pos  = i;
         hdr_tab[i].data = hdr_ref[175 - 8 * i -: 8];
      end
      for (int d = 0; d < 2; d++) begin
         flen[d] = 0; gap[d] = 0; first_gap[d] = 0; done_pos[d] = -1;
         done_seq[d] = 16'd0; starts[d] = 0; discard[d] = 1'b0;
      end

      ifa.enable = 1'b1;
      ifa.err_inject = 1'b0;
      ifb.enable = 1'b0;
      ifb.err_inject = 1'b0;
      #2;
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      repeat (3) @(posedge clk_125);
      #1;
      check("reset_phy_rst", ifa.phy_rst, 1'b0);
      check("reset_phy_en", ifa.phy_en, 1'b0);
      check("reset_phy_data", ifa.phy_data, 8'h00);
      check("reset_busy", ifa.busy, 1'b0);
      check("reset_frame_seq", ifa.frame_seq, 16'd0);

      // Frame 0 clean; frame 1 has enable dropped in its header and two errored payload bytes.
      exp_a.push_back('{46, 46, 1'b0, 16'd0, -1, -1, 0});
      exp_a.push_back('{46, 46, 1'b0, 16'd1, 5, 6, 12});
      @(negedge clk_125);
      rst_n_a = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk_125);
         #1;
         check($sformatf("a_phy_rst_edge%0d", e), ifa.phy_rst, (e >= 4) ? 1'b1 : 1'b0);
         if (e >= 4) begin
            check($sformatf("a_phy_en_edge%0d", e), ifa.phy_en, (e == 5) ? 1'b1 : 1'b0);
            check($sformatf("a_busy_edge%0d", e), ifa.busy, (e == 5) ? 1'b1 : 1'b0);
         end
      end
      check("a_first_byte", ifa.phy_data, 8'h55);

      wait_starts(0, 2, 400);
      negs(10);
      ifa.enable = 1'b0;
      negs(16);
      ifa.err_inject = 1'b1;
      negs(2);
      ifa.err_inject = 1'b0;
      negs(150);
      check("a_no_frame_after_enable_drop", starts[0], 2);
      check("a_frame_seq_after_two", ifa.frame_seq, 16'd2);
      check("a_busy_idle", ifa.busy, 1'b0);
      check("a_scoreboard_drained", exp_a.size(), 0);

      // Asynchronous reset in the middle of a payload.
      ifa.enable = 1'b1;
      wait_starts(0, 3, 100);
      negs(30);
      discard[0] = 1'b1;
      rst_n_a = 1'b0;
      #1;
      check("a_async_phy_en", ifa.phy_en, 1'b0);
      check("a_async_phy_rst", ifa.phy_rst, 1'b0);
      check("a_async_frame_seq", ifa.frame_seq, 16'd0);
      check("a_async_busy", ifa.busy, 1'b0);
      ifa.enable = 1'b0;
      repeat (2) @(negedge clk_125);
      rst_n_a = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk_125);
         #1;
         check($sformatf("a_rerun_phy_rst_edge%0d", e), ifa.phy_rst, (e >= 4) ? 1'b1 : 1'b0);
      end
      check("a_rerun_no_enable", ifa.phy_en, 1'b0);
      exp_a.push_back('{46, 46, 1'b0, 16'd0, -1, -1, 0});
      ifa.enable = 1'b1;
      wait_starts(0, 4, 50);
      negs(5);
      ifa.enable = 1'b0;
      negs(120);
      check("a_after_reset_frames", starts[0], 4);
      check("a_scoreboard_drained_2", exp_a.size(), 0);

      // Session-limited generator: short constant payload, FRAME_COUNT=3.
      for (int s = 0; s < 2; s++) begin
         for (int f = 0; f < 3; f++) begin
            exp_b.push_back('{10, 46, 1'b1, 16'(3 * s + f), -1, -1, (f == 0) ? 0 : 12});
         end
         if (s == 0) begin
            ifb.enable = 1'b1;
            @(negedge clk_125);
            rst_n_b = 1'b1;
         end else begin
            ifb.enable = 1'b0;
            negs(3);
            ifb.enable = 1'b1;
         end
         wait_starts(1, 3 * (s + 1), 600);
         negs(150);
         check($sformatf("b_session%0d_frames", s), starts[1], 3 * (s + 1));
         check($sformatf("b_session%0d_frame_seq", s), ifb.frame_seq, 16'(3 * (s + 1)));
         check($sformatf("b_session%0d_busy", s), ifb.busy, 1'b0);
         check($sformatf("b_session%0d_drained", s), exp_b.size(), 0);
      end
      ifb.enable = 1'b0;
      negs(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
